// File: rtl/aes_pkg.sv
// Shared AES-128 types and constants for the key schedule and cipher datapath.
package aes_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_NUM_RK = 11;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } ke_state_e;

  // Round 0 carries the raw key and has no Rcon; it maps to zero.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) r = RCON[idx];
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; one byte in, one substituted byte out.
module aes_sbox (
  input  logic [7:0] val,
  output logic [7:0] sub
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub = SBOX[val];

endmodule

// File: rtl/aes128_key_expander.sv
// AES-128 key schedule: latches a cipher key on start and writes round keys
// 0..10 into the round key memory, one per clock, then pulses done.
module aes128_key_expander
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 11,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] key,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  if (DATA_WIDTH != AES_KEY_W) begin : g_width_check
    $error("aes128_key_expander: DATA_WIDTH must be 128");
  end

  ke_state_e             state, state_n;
  logic [ADDR_WIDTH-1:0] rnd, rnd_n;
  aes_block_t            rk_reg, rk_n, rk_next;
  logic                  busy_n, done_n, we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] din_n;

  aes_word_t w0, w1, w2, w3, rot, subw, t, n0, n1, n2, n3;

  assign w0  = rk_reg[127:96];
  assign w1  = rk_reg[95:64];
  assign w2  = rk_reg[63:32];
  assign w3  = rk_reg[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .val (rot[8*b +: 8]),
      .sub (subw[8*b +: 8])
    );
  end

  assign t       = subw ^ {rcon_lookup(4'(rnd)), 24'h000000};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  always_comb begin
    state_n = state;
    rnd_n   = rnd;
    rk_n    = rk_reg;
    busy_n  = busy;
    done_n  = 1'b0;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    din_n   = mem_din;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          rk_n    = key;
          rnd_n   = '0;
          busy_n  = 1'b1;
          state_n = EXPAND;
        end
      end
      EXPAND: begin
        we_n   = 1'b1;
        addr_n = rnd;
        busy_n = 1'b1;
        // Round 0 writes the latched key untouched; later rounds advance the schedule.
        if (rnd == '0) begin
          din_n = rk_reg;
        end else begin
          din_n = rk_next;
          rk_n  = rk_next;
        end
        if (rnd == ADDR_WIDTH'(DEPTH - 1)) state_n = DONE;
        else                               rnd_n   = rnd + 1'b1;
      end
      DONE: begin
        busy_n = 1'b1;
        // First DONE cycle raises the pulse; the second drops it and releases busy.
        if (!done) begin
          done_n = 1'b1;
        end else begin
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rnd      <= '0;
      rk_reg   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state    <= state_n;
      rnd      <= rnd_n;
      rk_reg   <= rk_n;
      busy     <= busy_n;
      done     <= done_n;
      mem_we   <= we_n;
      mem_addr <= addr_n;
      mem_din  <= din_n;
    end
  end

endmodule
